// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hitbox vs hurtbox resolution, health and
// hitstun tracking, and the round FIGHT/KO/RESTART sequence.
module combat_resolver #(
  parameter int MAX_HEALTH     = 100,
  parameter int DAMAGE         = 10,
  parameter int ACTIVE_STATE   = 4,
  parameter int HITSTUN_FRAMES = 8,
  parameter int KO_FRAMES      = 120,
  parameter int HW             = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic [3:0]    p1_state,
  input  logic [3:0]    p2_state,
  input  logic [9:0]    p1_hit_x1,
  input  logic [9:0]    p1_hit_x2,
  input  logic [9:0]    p1_hit_y1,
  input  logic [9:0]    p1_hit_y2,
  input  logic [9:0]    p2_hit_x1,
  input  logic [9:0]    p2_hit_x2,
  input  logic [9:0]    p2_hit_y1,
  input  logic [9:0]    p2_hit_y2,
  input  logic [9:0]    p1_hurt_x1,
  input  logic [9:0]    p1_hurt_x2,
  input  logic [9:0]    p1_hurt_y1,
  input  logic [9:0]    p1_hurt_y2,
  input  logic [9:0]    p2_hurt_x1,
  input  logic [9:0]    p2_hurt_x2,
  input  logic [9:0]    p2_hurt_y1,
  input  logic [9:0]    p2_hurt_y2,
  output logic [HW-1:0] p1_health,
  output logic [HW-1:0] p2_health,
  output logic          p1_hit,
  output logic          p2_hit,
  output logic          p1_stunned,
  output logic          p2_stunned,
  output logic [1:0]    round_state,
  output logic [1:0]    winner,
  output logic          round_restart
);

  localparam logic [HW-1:0] LP_MAX = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] LP_DMG = HW'(DAMAGE);
  localparam logic [3:0]    LP_ACT = 4'(ACTIVE_STATE);
  localparam logic [7:0]    LP_STUN = 8'(HITSTUN_FRAMES);
  localparam logic [7:0]    LP_KO_LAST = 8'(KO_FRAMES - 1);

  typedef enum logic [1:0] {
    S_FIGHT   = 2'd0,
    S_KO      = 2'd1,
    S_RESTART = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [HW-1:0] r_h1;
  logic [HW-1:0] r_h2;
  logic [7:0]    r_stun1;
  logic [7:0]    r_stun2;
  logic          r_cons1;
  logic          r_cons2;
  logic [1:0]    r_winner;
  logic [7:0]    r_ko_cnt;
  logic          r_p1_hit;
  logic          r_p2_hit;

  logic          w_ovl1;
  logic          w_ovl2;
  logic          w_fight_tick;
  logic          w_decay;
  logic          w_hit1;
  logic          w_hit2;
  logic [HW-1:0] w_h1_nxt;
  logic [HW-1:0] w_h2_nxt;
  logic [7:0]    w_stun1_nxt;
  logic [7:0]    w_stun2_nxt;
  logic          w_cons1_nxt;
  logic          w_cons2_nxt;
  logic          w_ko_go;
  logic          w_enter_rst;

  function automatic logic [9:0] f_min(
    input logic [9:0] a,
    input logic [9:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [9:0] f_max(
    input logic [9:0] a,
    input logic [9:0] b
  );
    return (a < b) ? b : a;
  endfunction

  // Corners may arrive in either order; normalise before the inclusive test.
  function automatic logic f_span(
    input logic [9:0] a1,
    input logic [9:0] a2,
    input logic [9:0] b1,
    input logic [9:0] b2
  );
    return (f_min(a1, a2) <= f_max(b1, b2)) &&
           (f_min(b1, b2) <= f_max(a1, a2));
  endfunction

  function automatic logic [HW-1:0] f_dmg(
    input logic [HW-1:0] h
  );
    return (h > LP_DMG) ? h - LP_DMG : '0;
  endfunction

  function automatic logic [7:0] f_stun(
    input logic       hit,
    input logic       dec,
    input logic [7:0] s
  );
    if (hit)
      return LP_STUN;
    else if (dec && s != 8'd0)
      return s - 8'd1;
    else
      return s;
  endfunction

  function automatic logic f_cons(
    input logic hit,
    input logic tick,
    input logic act,
    input logic c
  );
    if (hit)
      return 1'b1;
    else if (tick && !act)
      return 1'b0;
    else
      return c;
  endfunction

  assign w_ovl1 =
    f_span(p1_hit_x1, p1_hit_x2, p2_hurt_x1, p2_hurt_x2) &&
    f_span(p1_hit_y1, p1_hit_y2, p2_hurt_y1, p2_hurt_y2);

  assign w_ovl2 =
    f_span(p2_hit_x1, p2_hit_x2, p1_hurt_x1, p1_hurt_x2) &&
    f_span(p2_hit_y1, p2_hit_y2, p1_hurt_y1, p1_hurt_y2);

  assign w_fight_tick = frame_tick && (r_state == S_FIGHT);
  assign w_decay = frame_tick && (r_state != S_RESTART);

  // w_hit1: P1 lands on P2; w_hit2: P2 lands on P1.
  assign w_hit1 = w_fight_tick && (p1_state == LP_ACT) &&
                  !r_cons1 && (r_stun1 == 8'd0) && w_ovl1;
  assign w_hit2 = w_fight_tick && (p2_state == LP_ACT) &&
                  !r_cons2 && (r_stun2 == 8'd0) && w_ovl2;

  assign w_h1_nxt = w_hit2 ? f_dmg(r_h1) : r_h1;
  assign w_h2_nxt = w_hit1 ? f_dmg(r_h2) : r_h2;

  assign w_stun1_nxt = f_stun(w_hit2, w_decay, r_stun1);
  assign w_stun2_nxt = f_stun(w_hit1, w_decay, r_stun2);

  assign w_cons1_nxt =
    f_cons(w_hit1, frame_tick, p1_state == LP_ACT, r_cons1);
  assign w_cons2_nxt =
    f_cons(w_hit2, frame_tick, p2_state == LP_ACT, r_cons2);

  assign w_ko_go = (w_h1_nxt == '0) || (w_h2_nxt == '0);
  assign w_enter_rst = (r_state == S_KO) && (w_nxt == S_RESTART);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_FIGHT;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_FIGHT:
        if (w_ko_go)
          w_nxt = S_KO;
      S_KO:
        if (frame_tick && r_ko_cnt == LP_KO_LAST)
          w_nxt = S_RESTART;
      S_RESTART:
        w_nxt = S_FIGHT;
      default:
        w_nxt = S_FIGHT;
    endcase
  end

  always_comb begin
    round_state   = r_state;
    round_restart = (r_state == S_RESTART);
  end

  // Restart values are loaded on entry so they are visible with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h1     <= LP_MAX;
      r_h2     <= LP_MAX;
      r_stun1  <= 8'd0;
      r_stun2  <= 8'd0;
      r_cons1  <= 1'b0;
      r_cons2  <= 1'b0;
      r_winner <= 2'd0;
      r_ko_cnt <= 8'd0;
      r_p1_hit <= 1'b0;
      r_p2_hit <= 1'b0;
    end else begin
      r_p1_hit <= w_hit2;
      r_p2_hit <= w_hit1;
      if (w_enter_rst) begin
        r_h1     <= LP_MAX;
        r_h2     <= LP_MAX;
        r_stun1  <= 8'd0;
        r_stun2  <= 8'd0;
        r_cons1  <= 1'b0;
        r_cons2  <= 1'b0;
        r_winner <= 2'd0;
        r_ko_cnt <= 8'd0;
      end else begin
        r_h1    <= w_h1_nxt;
        r_h2    <= w_h2_nxt;
        r_stun1 <= w_stun1_nxt;
        r_stun2 <= w_stun2_nxt;
        r_cons1 <= w_cons1_nxt;
        r_cons2 <= w_cons2_nxt;
        if (r_state == S_FIGHT && w_nxt == S_KO) begin
          r_winner <= {w_h1_nxt == '0, w_h2_nxt == '0};
          r_ko_cnt <= 8'd0;
        end else if (r_state == S_KO && frame_tick) begin
          r_ko_cnt <= r_ko_cnt + 8'd1;
        end
      end
    end
  end

  assign p1_health  = r_h1;
  assign p2_health  = r_h2;
  assign p1_hit     = r_p1_hit;
  assign p2_hit     = r_p2_hit;
  assign p1_stunned = (r_stun1 != 8'd0);
  assign p2_stunned = (r_stun2 != 8'd0);
  assign winner     = r_winner;

endmodule

// File: tb/tb_combat_resolver.sv
// tb_combat_resolver: directed and random frames against a
// rule-level model of the two-player combat round.
module tb_combat_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [3:0] st_in [2];
  logic [9:0] hx1 [2];
  logic [9:0] hx2 [2];
  logic [9:0] hy1 [2];
  logic [9:0] hy2 [2];
  logic [9:0] ux1 [2];
  logic [9:0] ux2 [2];
  logic [9:0] uy1 [2];
  logic [9:0] uy2 [2];

  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic       p1_hit;
  logic       p2_hit;
  logic       p1_stunned;
  logic       p2_stunned;
  logic [1:0] round_state;
  logic [1:0] winner;
  logic       round_restart;

  int n_chk = 0;
  int n_fail = 0;

  int m_hp [2];
  int m_st [2];
  bit m_cons [2];
  bit m_pulse [2];
  int m_rnd;
  int m_win;
  int m_ko;

  always #5 clk = ~clk;

  combat_resolver dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .p1_state(st_in[0]),
    .p2_state(st_in[1]),
    .p1_hit_x1(hx1[0]),
    .p1_hit_x2(hx2[0]),
    .p1_hit_y1(hy1[0]),
    .p1_hit_y2(hy2[0]),
    .p2_hit_x1(hx1[1]),
    .p2_hit_x2(hx2[1]),
    .p2_hit_y1(hy1[1]),
    .p2_hit_y2(hy2[1]),
    .p1_hurt_x1(ux1[0]),
    .p1_hurt_x2(ux2[0]),
    .p1_hurt_y1(uy1[0]),
    .p1_hurt_y2(uy2[0]),
    .p2_hurt_x1(ux1[1]),
    .p2_hurt_x2(ux2[1]),
    .p2_hurt_y1(uy1[1]),
    .p2_hurt_y2(uy2[1]),
    .p1_health(p1_health),
    .p2_health(p2_health),
    .p1_hit(p1_hit),
    .p2_hit(p2_hit),
    .p1_stunned(p1_stunned),
    .p2_stunned(p2_stunned),
    .round_state(round_state),
    .winner(winner),
    .round_restart(round_restart)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit span(int a1, int a2, int b1, int b2);
    int alo = (a1 < a2) ? a1 : a2;
    int ahi = (a1 < a2) ? a2 : a1;
    int blo = (b1 < b2) ? b1 : b2;
    int bhi = (b1 < b2) ? b2 : b1;
    return (alo <= bhi) && (blo <= ahi);
  endfunction

  function automatic bit lands(int a);
    int d = 1 - a;
    return span(int'(hx1[a]), int'(hx2[a]), int'(ux1[d]), int'(ux2[d])) &&
           span(int'(hy1[a]), int'(hy2[a]), int'(uy1[d]), int'(uy2[d]));
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_hp[p] = 100;
      m_st[p] = 0;
      m_cons[p] = 0;
      m_pulse[p] = 0;
    end
    m_rnd = 0;
    m_win = 0;
    m_ko = 0;
  endtask

  task automatic model_clock(input bit tick);
    bit h [2];
    h[0] = 0;
    h[1] = 0;
    if (m_rnd == 2) begin
      m_rnd = 0;
      m_pulse[0] = 0;
      m_pulse[1] = 0;
    end else begin
      if (tick && m_rnd == 0)
        for (int a = 0; a < 2; a++)
          h[1-a] = (st_in[a] == 4'd4) && !m_cons[a] &&
                   (m_st[a] == 0) && lands(a);
      for (int p = 0; p < 2; p++) begin
        m_pulse[p] = h[p];
        if (h[p]) begin
          m_hp[p] = (m_hp[p] >= 10) ? m_hp[p] - 10 : 0;
          m_st[p] = 8;
        end else if (tick && m_st[p] > 0) begin
          m_st[p]--;
        end
      end
      for (int a = 0; a < 2; a++)
        if (h[1-a])
          m_cons[a] = 1;
        else if (tick && st_in[a] != 4'd4)
          m_cons[a] = 0;
      if (m_rnd == 0 && (m_hp[0] == 0 || m_hp[1] == 0)) begin
        m_rnd = 1;
        m_win = (m_hp[0] == 0 ? 2 : 0) + (m_hp[1] == 0 ? 1 : 0);
        m_ko = 0;
      end else if (m_rnd == 1 && tick) begin
        m_ko++;
        if (m_ko == 120) begin
          m_rnd = 2;
          for (int p = 0; p < 2; p++) begin
            m_hp[p] = 100;
            m_st[p] = 0;
            m_cons[p] = 0;
          end
          m_win = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("p1_health", p1_health, m_hp[0]);
    chk("p2_health", p2_health, m_hp[1]);
    chk("p1_hit", p1_hit, m_pulse[0]);
    chk("p2_hit", p2_hit, m_pulse[1]);
    chk("p1_stunned", p1_stunned, m_st[0] != 0);
    chk("p2_stunned", p2_stunned, m_st[1] != 0);
    chk("round_state", round_state, m_rnd);
    chk("winner", winner, m_win);
    chk("round_restart", round_restart, m_rnd == 2);
  endtask

  task automatic step(input bit tick);
    frame_tick = tick;
    @(posedge clk);
    model_clock(tick);
    #1;
    frame_tick = 1'b0;
    check_all();
  endtask

  task automatic set_hit(input int p, input int x1, input int x2,
                         input int y1, input int y2);
    hx1[p] = 10'(x1);
    hx2[p] = 10'(x2);
    hy1[p] = 10'(y1);
    hy2[p] = 10'(y2);
  endtask

  task automatic set_hurt(input int p, input int x1, input int x2,
                          input int y1, input int y2);
    ux1[p] = 10'(x1);
    ux2[p] = 10'(x2);
    uy1[p] = 10'(y1);
    uy2[p] = 10'(y2);
  endtask

  task automatic rnd_pair(output int a, output int b);
    int lo = int'($urandom_range(0, 300));
    int hi = lo + int'($urandom_range(5, 100));
    if ($urandom_range(0, 1) == 1) begin
      a = lo;
      b = hi;
    end else begin
      a = hi;
      b = lo;
    end
  endtask

  task automatic randomize_frame();
    int a, b, c, d;
    for (int p = 0; p < 2; p++) begin
      st_in[p] = ($urandom_range(0, 1) == 1) ? 4'd4
                                             : 4'($urandom_range(0, 5));
      rnd_pair(a, b);
      rnd_pair(c, d);
      set_hit(p, a, b, c, d);
      rnd_pair(a, b);
      rnd_pair(c, d);
      set_hurt(p, a, b, c, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    st_in[0] = 4'd0;
    st_in[1] = 4'd0;
    set_hit(0, 247, 323, 194, 227);
    set_hurt(0, 200, 240, 170, 320);
    set_hit(1, 900, 950, 0, 10);
    set_hurt(1, 506, 457, 170, 320);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Hitbox well short of a reversed hurtbox: no contact.
    st_in[0] = 4'd4;
    step(1'b1);
    step(1'b0);
    chk("t1_p2_health", p2_health, 100);
    st_in[0] = 4'd0;
    step(1'b1);

    // Reversed hurtbox in reach; held active window hits once.
    set_hurt(1, 336, 287, 170, 320);
    st_in[0] = 4'd4;
    step(1'b1);
    chk("t2_pulse", p2_hit, 1);
    chk("t2_health", p2_health, 90);
    step(1'b1);
    chk("t2_no_repeat", p2_hit, 0);
    step(1'b1);
    st_in[0] = 4'd0;
    repeat (5) step(1'b1);
    chk("t2_stun_last", p2_stunned, 1);
    step(1'b1);
    chk("t2_stun_done", p2_stunned, 0);

    // Trade: both land on the same tick.
    set_hit(1, 220, 260, 180, 230);
    st_in[0] = 4'd4;
    st_in[1] = 4'd4;
    step(1'b1);
    chk("trade_p1_hit", p1_hit, 1);
    chk("trade_p2_hit", p2_hit, 1);
    chk("trade_p1_hp", p1_health, 90);
    chk("trade_p2_hp", p2_health, 80);
    chk("trade_p1_stun", p1_stunned, 1);
    chk("trade_p2_stun", p2_stunned, 1);
    st_in[0] = 4'd0;
    st_in[1] = 4'd0;
    repeat (8) step(1'b1);

    // Stunned attacker cannot land.
    st_in[1] = 4'd4;
    step(1'b1);
    st_in[1] = 4'd0;
    repeat (3) step(1'b1);
    st_in[0] = 4'd4;
    step(1'b1);
    chk("stun_block_pulse", p2_hit, 0);
    chk("stun_block_hp", p2_health, 80);
    st_in[0] = 4'd0;
    repeat (8) step(1'b1);

    // Repeated distinct attacks knock P2 out.
    for (int i = 0; i < 40 && m_rnd == 0; i++) begin
      st_in[0] = (i % 2 == 0) ? 4'd4 : 4'd5;
      step(1'b1);
    end
    chk("ko_state", round_state, 1);
    chk("ko_winner", winner, 1);
    chk("ko_p2_hp", p2_health, 0);
    st_in[0] = 4'd0;

    // KO hold, then one-cycle restart.
    for (int i = 0; i < 119; i++) begin
      step(1'b1);
      if (i % 10 == 3)
        step(1'b0);
    end
    chk("ko_hold", round_state, 1);
    step(1'b1);
    chk("rs_state", round_state, 2);
    chk("rs_pulse", round_restart, 1);
    chk("rs_p1_hp", p1_health, 100);
    chk("rs_p2_hp", p2_health, 100);
    chk("rs_winner", winner, 0);
    step(1'b0);
    chk("rs_back", round_state, 0);
    chk("rs_pulse_off", round_restart, 0);

    // Random frames.
    repeat (400) begin
      randomize_frame();
      step($urandom_range(0, 2) != 0);
    end

    // Drive another KO, then reset asynchronously mid-KO.
    set_hit(0, 247, 323, 194, 227);
    set_hurt(0, 200, 240, 170, 320);
    set_hit(1, 900, 950, 0, 10);
    set_hurt(1, 336, 287, 170, 320);
    st_in[1] = 4'd0;
    for (int i = 0; i < 300 && m_rnd != 1; i++) begin
      st_in[0] = (i % 2 == 0) ? 4'd4 : 4'd5;
      step(1'b1);
    end
    chk("ko2_state", round_state, 1);
    st_in[0] = 4'd0;
    repeat (10) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_no_pulse", round_restart, 0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Downstream consumer of both player FSM instances.
- Each game frame, compares each player's attack hitbox against the opponent's hurtbox and applies damage once per attack window.
- Tracks health and hitstun per player, and runs the round KO/restart sequence.
- Outputs drive the HUD renderer and the players' stun/restart inputs.

Parameters:
- MAX_HEALTH, 100, health loaded at reset and restart.
- DAMAGE, 10, health removed per registered hit.
- ACTIVE_STATE, 4, player state code in which the hitbox is live (attack-end phase).
- HITSTUN_FRAMES, 8, frames of stun after being hit.
- KO_FRAMES, 120, frames held in KO before restart.
- HW, 7, health width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per game frame; all evaluation happens only on tick cycles.
- p1_state, p2_state  in  4  player FSM states.
- p1_hit_x1/x2/y1/y2, p2_hit_x1/x2/y1/y2  in  10 each  attack hitbox corners.
- p1_hurt_x1/x2/y1/y2, p2_hurt_x1/x2/y1/y2  in  10 each  hurtbox corners.
- p1_health, p2_health  out  HW  current health.
- p1_hit, p2_hit  out  1  one-cycle pulse: that player was hit this frame.
- p1_stunned, p2_stunned  out  1  hitstun counter nonzero.
- round_state  out  2  0=FIGHT, 1=KO, 2=RESTART.
- winner  out  2  0=none, 1=P1, 2=P2, 3=draw.
- round_restart  out  1  one-cycle pulse to reset players.

Behaviour:
- Reset (async):
  - Health = MAX_HEALTH; stun counters 0.
  - Consumed flags 0; round_state FIGHT; winner 0.
  - All pulses 0; KO counter 0.
- Box normalisation: corners may arrive reversed (right-side hurtbox has x1>x2). Use lo=min, hi=max per axis before comparing.
- Overlap: inclusive on both axes. Condition is hit_lo<=hurt_hi and hurt_lo<=hit_hi for x and for y.
- Hit condition for attacker A on tick in FIGHT, all checked with pre-tick values:
  - A state == ACTIVE_STATE.
  - A consumed flag 0.
  - A stun counter 0.
  - A hitbox overlaps defender hurtbox.
- Consumed flag: set when A lands a hit; cleared on any tick where A state != ACTIVE_STATE. Result: at most one hit per active window.
- Trades: both hits may register on the same tick. Both players are damaged and both are stunned.
- Damage: health = health-DAMAGE, saturating at 0.
- Defender stun counter is loaded with HITSTUN_FRAMES on a hit, including a reload while already stunned.
- Stun counters decrement by 1 on every tick when nonzero and no reload occurs.
- Latency: health, stun and pulses update on the clock edge ending the tick cycle. pX_hit is high exactly one cycle after that edge-triggering tick, then clears.
- Non-tick cycles: hold all state; pulses 0.
- FSM:
  - FIGHT -> KO: on the edge where any health becomes 0. winner=1 if only P2 is 0, 2 if only P1 is 0, 3 if both. KO counter cleared.
  - KO: hits ignored, health frozen, stun still decays. KO counter increments each tick. After KO_FRAMES ticks, go to RESTART.
  - RESTART (one cycle, independent of tick): round_restart=1; health=MAX_HEALTH; stun, consumed and winner cleared. Then -> FIGHT.
- Reset mid-KO or mid-restart returns immediately to the reset values; no round_restart pulse is emitted.
- Width rules:
  - Coordinates are unsigned 10-bit; no wrap handling beyond the inputs.
  - Stun and KO counters are 8-bit.

Test Plan:
- P1 posx 210 (hitbox 247..323 x 194..227), P2 hurtbox x1=506,x2=457, y 170..320; P1 state 4 on a tick -> no hit, p2_health stays 100.
- P2 hurtbox x1=336,x2=287 (reversed), P1 state 4 held for 3 ticks -> single p2_hit pulse one cycle after the first tick; p2_health=90; p2_stunned for 8 ticks.
- Both players in state 4 with mutual overlap on the same tick -> both healths 90, both hit pulses, both stunned.
- P1 lands repeated distinct attacks (state 4, then 5, then 4), P2 at health 10 -> p2_health=0, round_state=1, winner=1.
- After 120 ticks in KO -> round_state=2 for one cycle with round_restart=1, healths 100, winner 0, then round_state=0.
- P1 stunned (counter 5) in state 4 with overlap -> no hit; async rst asserted mid-KO -> healths 100, round_state 0, no restart pulse.
